// File: rtl/hdp_sram_1rw_mask_pipe_pkg.sv
// Shared types and helpers for the 1RW masked SRAM model: FSM states,
// latency limits and the lane/spare write merge.
package hdp_sram_1rw_mask_pipe_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    localparam int unsigned RD_LAT_MIN  = 1;
    localparam int unsigned RD_LAT_MAX  = 4;
    localparam int unsigned MERGE_MAX_W = 256;
    localparam int unsigned MERGE_IDX_W = $clog2(MERGE_MAX_W);

    // Bits below data_w follow their lane's mask bit; bits in [data_w, word_w) follow spare_wen.
    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0] old_w,
        input logic [MERGE_MAX_W-1:0] din_w,
        input logic [MERGE_MAX_W-1:0] wmask,
        input logic                   spare_wen,
        input int unsigned            data_w,
        input int unsigned            mask_w,
        input int unsigned            word_w
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int unsigned b = 0; b < MERGE_MAX_W; b++) begin
            if (b < data_w) begin
                if (wmask[MERGE_IDX_W'(b / mask_w)]) res[MERGE_IDX_W'(b)] = din_w[MERGE_IDX_W'(b)];
            end else if (b < word_w) begin
                if (spare_wen) res[MERGE_IDX_W'(b)] = din_w[MERGE_IDX_W'(b)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hdp_sram_1rw_mask_pipe_if.sv
// Access bus of the 1RW masked SRAM model: command/write data in, read data/status out.
interface hdp_sram_1rw_mask_pipe_if #(
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned WORD_WIDTH = 33
);
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic                  spare_wen0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [WORD_WIDTH-1:0] din0;
    logic [WORD_WIDTH-1:0] dout0;
    logic                  dout0_valid;
    logic                  init_done0;

    modport master (
        output csb0, web0, wmask0, spare_wen0, addr0, din0,
        input  dout0, dout0_valid, init_done0
    );

    modport slave (
        input  csb0, web0, wmask0, spare_wen0, addr0, din0,
        output dout0, dout0_valid, init_done0
    );
endinterface

// File: rtl/hdp_sram_1rw_mask_pipe_rd_pipe.sv
// Fixed-latency return pipe: LATENCY stages of {valid,data} feeding an output
// register that only loads on a valid word and otherwise holds.
module hdp_sram_1rw_mask_pipe_rd_pipe #(
    parameter int unsigned WIDTH   = 33,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o
);

    logic [LATENCY-1:0]            vld_q;
    logic [LATENCY:0]              vld_sh_c;
    logic [LATENCY-1:0][WIDTH-1:0] dat_q;
    logic [LATENCY:0][WIDTH-1:0]   dat_sh_c;
    logic                          out_valid_q;
    logic [WIDTH-1:0]              out_data_q;

    assign vld_sh_c = {vld_q, in_valid_i};
    assign dat_sh_c = {dat_q, in_data_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            vld_q       <= vld_sh_c[LATENCY-1:0];
            out_valid_q <= vld_q[LATENCY-1];
            if (vld_q[LATENCY-1]) out_data_q <= dat_q[LATENCY-1];
        end
    end

    // Payload stages need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        dat_q <= dat_sh_c[LATENCY-1:0];
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/hdp_sram_1rw_mask_pipe.sv
// Behavioural 1RW SRAM macro model with lane write masks, spare bits,
// pipelined read return, optional write readback and a post-reset clear sweep.
module hdp_sram_1rw_mask_pipe
    import hdp_sram_1rw_mask_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MASK_WIDTH     = 8,
    parameter int unsigned NUM_WMASKS     = DATA_WIDTH / MASK_WIDTH,
    parameter int unsigned SPARE_BITS     = 1,
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned WRITE_READBACK = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    clk0,
    input  logic                    rst0,
    hdp_sram_1rw_mask_pipe_if.slave bus
);

    localparam int unsigned WORD_W = DATA_WIDTH + SPARE_BITS;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX ||
        (DATA_WIDTH % MASK_WIDTH) != 0 || NUM_WMASKS != DATA_WIDTH / MASK_WIDTH ||
        WORD_W > MERGE_MAX_W) begin : g_bad_params
        $error("hdp_sram_1rw_mask_pipe: illegal parameter combination");
    end

    sram_state_e           state_q;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic                  init_done_q;
    logic [WORD_W-1:0]     mem [DEPTH];

    logic                  bus_x_c;
    logic                  acc_c;
    logic                  wr_c;
    logic [WORD_W-1:0]     rd_word_c;
    logic [WORD_W-1:0]     merged_c;
    logic                  pipe_vld_c;
    logic [WORD_W-1:0]     pipe_data_c;
    logic                  dout_vld_w;
    logic [WORD_W-1:0]     dout_w;

    // Clear sweep: one word per edge, READY after the last address is zeroed.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_ptr_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
                    if (&clr_ptr_q) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end
                end
                ST_READY: init_done_q <= 1'b1;
                default:  state_q     <= ST_READY;
            endcase
        end
    end

    // An unknown select or write enable must never corrupt the array.
    assign bus_x_c   = $isunknown({bus.csb0, bus.web0});
    assign acc_c     = init_done_q && !bus_x_c && !bus.csb0;
    assign wr_c      = acc_c && !bus.web0;
    assign rd_word_c = mem[bus.addr0];
    assign merged_c  = WORD_W'(lane_merge(MERGE_MAX_W'(rd_word_c), MERGE_MAX_W'(bus.din0),
                                          MERGE_MAX_W'(bus.wmask0), bus.spare_wen0,
                                          DATA_WIDTH, MASK_WIDTH, WORD_W));

    always_ff @(posedge clk0) begin
        if (state_q == ST_CLEAR) mem[clr_ptr_q] <= '0;
        else if (wr_c)           mem[bus.addr0] <= merged_c;
    end

    assign pipe_vld_c  = acc_c && (bus.web0 || (WRITE_READBACK != 0));
    assign pipe_data_c = bus.web0 ? rd_word_c : merged_c;

    hdp_sram_1rw_mask_pipe_rd_pipe #(
        .WIDTH   (WORD_W),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk         (clk0),
        .rst         (rst0),
        .in_valid_i  (pipe_vld_c),
        .in_data_i   (pipe_data_c),
        .out_valid_o (dout_vld_w),
        .out_data_o  (dout_w)
    );

    assign bus.dout0       = dout_w;
    assign bus.dout0_valid = dout_vld_w;
    assign bus.init_done0  = init_done_q;

endmodule
